// File: rtl/rtc_alrm_sched_pkg.sv
// Shared types and defaults for the RTC alarm-slot scheduler.
package rtc_alrm_sched_pkg;

    localparam int unsigned RTC_CNT_WIDTH      = 32;
    localparam int unsigned RTC_SCHED_NUM_SLOT = 4;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        PROG,
        ARMED,
        HIT
    } sched_state_e;

    typedef struct packed {
        logic                     pend;
        logic [RTC_CNT_WIDTH-1:0] tgt;
    } slot_t;

endpackage

// File: rtl/rtc_alrm_sel.sv
// Sequential minimum-distance selector: one candidate per cycle, ties keep the earlier one.
module rtc_alrm_sel
    import rtc_alrm_sched_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = RTC_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 first,
    input  logic                 cand_vld,
    input  logic [CNT_WIDTH-1:0] cand_dist,
    input  logic [CNT_WIDTH-1:0] cand_time,
    output logic [CNT_WIDTH-1:0] best_time
);

    logic                 best_vld;
    logic [CNT_WIDTH-1:0] best_dist;
    logic                 take;

    // Strictly-smaller distance replaces the current best, so lower indices win ties.
    always_comb begin
        take = cand_vld && (first || !best_vld || (cand_dist < best_dist));
    end

    // Best-candidate registers; the first scan step discards any previous result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_vld  <= 1'b0;
            best_dist <= '0;
            best_time <= '0;
        end else if (en) begin
            if (take) begin
                best_vld  <= 1'b1;
                best_dist <= cand_dist;
                best_time <= cand_time;
            end else if (first) begin
                best_vld  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rtc_alrm_sched.sv
// Multiplexes NUM_SLOT software alarm slots onto the single RTC alarm comparator.
module rtc_alrm_sched
    import rtc_alrm_sched_pkg::*;
#(
    parameter int unsigned NUM_SLOT  = RTC_SCHED_NUM_SLOT,
    parameter int unsigned CNT_WIDTH = RTC_CNT_WIDTH
) (
    input  logic                        rtc_clk_i,
    input  logic                        rtc_rst_i,
    input  logic [CNT_WIDTH-1:0]        cnt_i,
    input  logic                        set_valid_i,
    output logic                        set_ready_o,
    input  logic [$clog2(NUM_SLOT)-1:0] set_id_i,
    input  logic [CNT_WIDTH-1:0]        set_time_i,
    input  logic                        cancel_i,
    input  logic [$clog2(NUM_SLOT)-1:0] cancel_id_i,
    output logic [CNT_WIDTH-1:0]        alrm_o,
    output logic                        alrm_wr_o,
    output logic                        alrm_vld_o,
    output logic [NUM_SLOT-1:0]         pend_o,
    output logic [NUM_SLOT-1:0]         hit_o,
    input  logic [NUM_SLOT-1:0]         hit_clr_i,
    output logic                        irq_o
);

    localparam int unsigned IW = $clog2(NUM_SLOT);

    sched_state_e         state, state_nxt;
    logic [NUM_SLOT-1:0]  pend;
    logic [CNT_WIDTH-1:0] slot_time [NUM_SLOT];
    logic [IW-1:0]        scan_idx;
    logic                 scan_last;
    logic [CNT_WIDTH-1:0] alrm_q;
    logic                 alrm_vld_q;
    logic [NUM_SLOT-1:0]  hit_sts;
    logic [NUM_SLOT-1:0]  hit_vec;
    logic                 do_set, do_cancel;
    logic [CNT_WIDTH-1:0] cand_time, cand_dist, best_time;

    assign scan_last = (scan_idx == IW'(NUM_SLOT - 1));
    assign cand_time = slot_time[scan_idx];
    assign cand_dist = cand_time - cnt_i;
    assign do_set    = set_valid_i && set_ready_o;
    assign do_cancel = cancel_i && set_ready_o && !set_valid_i;

    // While PROG strobes, alrm_o shows the freshly selected value so the write carries it.
    assign alrm_o     = (state == PROG) ? best_time : alrm_q;
    assign alrm_vld_o = alrm_vld_q;
    assign pend_o     = pend;
    assign hit_o      = hit_vec;
    assign irq_o      = |hit_sts;

    rtc_alrm_sel #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_sel (
        .clk       (rtc_clk_i),
        .rst       (rtc_rst_i),
        .en        (state == SCAN),
        .first     (scan_idx == '0),
        .cand_vld  (pend[scan_idx]),
        .cand_dist (cand_dist),
        .cand_time (cand_time),
        .best_time (best_time)
    );

    // State register.
    always_ff @(posedge rtc_clk_i or posedge rtc_rst_i) begin
        if (rtc_rst_i) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state decode plus handshake and write strobe.
    always_comb begin
        state_nxt   = state;
        set_ready_o = 1'b0;
        alrm_wr_o   = 1'b0;
        case (state)
            IDLE: begin
                set_ready_o = 1'b1;
                if (set_valid_i || cancel_i) state_nxt = SCAN;
            end
            SCAN: begin
                if (scan_last) state_nxt = (|pend) ? PROG : IDLE;
            end
            PROG: begin
                alrm_wr_o = 1'b1;
                state_nxt = ARMED;
            end
            ARMED: begin
                set_ready_o = 1'b1;
                if (set_valid_i || cancel_i) state_nxt = SCAN;
                else if (cnt_i == alrm_q)    state_nxt = HIT;
            end
            HIT:     state_nxt = SCAN;
            default: state_nxt = IDLE;
        endcase
    end

    // Every pending slot sharing the matched target fires together.
    always_comb begin
        hit_vec = '0;
        for (int unsigned i = 0; i < NUM_SLOT; i++) begin
            hit_vec[i] = (state == HIT) && pend[i] && (slot_time[i] == alrm_q);
        end
    end

    // Slot table, scan pointer, armed alarm and sticky hit status.
    always_ff @(posedge rtc_clk_i or posedge rtc_rst_i) begin
        if (rtc_rst_i) begin
            pend       <= '0;
            for (int unsigned i = 0; i < NUM_SLOT; i++) slot_time[i] <= '0;
            scan_idx   <= '0;
            alrm_q     <= '0;
            alrm_vld_q <= 1'b0;
            hit_sts    <= '0;
        end else begin
            if (do_set) begin
                slot_time[set_id_i] <= set_time_i;
                pend[set_id_i]      <= 1'b1;
            end else if (do_cancel) begin
                pend[cancel_id_i]   <= 1'b0;
            end else if (state == HIT) begin
                pend <= pend & ~hit_vec;
            end

            scan_idx <= (state == SCAN && !scan_last) ? scan_idx + 1'b1 : '0;

            if (state == PROG) begin
                alrm_q     <= best_time;
                alrm_vld_q <= 1'b1;
            end else if (do_set || do_cancel || state == HIT) begin
                alrm_vld_q <= 1'b0;
            end

            hit_sts <= (hit_sts & ~hit_clr_i) | hit_vec;
        end
    end

endmodule

// File: tb/tb_rtc_alrm_sched.sv
// Scoreboard bench for rtc_alrm_sched: expected alarm writes and hits are queued at stimulus time.
module tb_rtc_alrm_sched;

    localparam int unsigned NS = 4;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] cnt = '0;
    logic          set_valid = 1'b0;
    logic          set_ready;
    logic [1:0]    set_id = '0;
    logic [CW-1:0] set_time = '0;
    logic          cancel = 1'b0;
    logic [1:0]    cancel_id = '0;
    logic [CW-1:0] alrm;
    logic          alrm_wr;
    logic          alrm_vld;
    logic [NS-1:0] pend;
    logic [NS-1:0] hit;
    logic [NS-1:0] hit_clr = '0;
    logic          irq;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        bit          is_hit;
        logic [31:0] val;
    } ev_t;
    ev_t sbq[$];

    rtc_alrm_sched #(
        .NUM_SLOT  (NS),
        .CNT_WIDTH (CW)
    ) dut (
        .rtc_clk_i   (clk),
        .rtc_rst_i   (rst),
        .cnt_i       (cnt),
        .set_valid_i (set_valid),
        .set_ready_o (set_ready),
        .set_id_i    (set_id),
        .set_time_i  (set_time),
        .cancel_i    (cancel),
        .cancel_id_i (cancel_id),
        .alrm_o      (alrm),
        .alrm_wr_o   (alrm_wr),
        .alrm_vld_o  (alrm_vld),
        .pend_o      (pend),
        .hit_o       (hit),
        .hit_clr_i   (hit_clr),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic push_wr(input logic [31:0] v);
        ev_t e;
        e.is_hit = 1'b0;
        e.val    = v;
        sbq.push_back(e);
    endtask

    task automatic push_hit(input logic [NS-1:0] m);
        ev_t e;
        e.is_hit = 1'b1;
        e.val    = 32'(m);
        sbq.push_back(e);
    endtask

    task automatic sb_pop(input bit is_hit, input logic [31:0] v);
        ev_t e;
        if (sbq.size() == 0) begin
            check_eq(is_hit ? "sb_unexpected_hit" : "sb_unexpected_wr", 64'(sbq.size()), 64'd1);
        end else begin
            e = sbq.pop_front();
            check_eq("sb_kind", 64'(is_hit), 64'(e.is_hit));
            check_eq(is_hit ? "sb_hit" : "sb_wr", 64'(v), 64'(e.val));
        end
    endtask

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (alrm_wr)   sb_pop(1'b0, alrm);
            if (hit != '0) sb_pop(1'b1, 32'(hit));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_set(input logic [1:0] id, input logic [CW-1:0] t);
        set_valid = 1'b1;
        set_id    = id;
        set_time  = t;
        tick();
        set_valid = 1'b0;
    endtask

    task automatic do_cancel(input logic [1:0] id);
        cancel    = 1'b1;
        cancel_id = id;
        tick();
        cancel    = 1'b0;
    endtask

    task automatic clear_hits(input logic [NS-1:0] m);
        hit_clr = m;
        tick();
        hit_clr = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #1;
        check_eq("rst_ready", 64'(set_ready), 64'd1);
        check_eq("rst_alrm", 64'(alrm), 64'd0);
        check_eq("rst_wr", 64'(alrm_wr), 64'd0);
        check_eq("rst_vld", 64'(alrm_vld), 64'd0);
        check_eq("rst_pend", 64'(pend), 64'd0);
        check_eq("rst_hit", 64'(hit), 64'd0);
        check_eq("rst_irq", 64'(irq), 64'd0);
        settle(2);
        rst = 1'b0;
        settle(1);

        // Single slot: latency and hit
        cnt = 50;
        push_wr(100);
        do_set(0, 100);
        check_eq("scan_ready", 64'(set_ready), 64'd0);
        for (int c = 1; c <= NS + 1; c++) begin
            check_eq("lat_wr", 64'(alrm_wr), 64'(c == NS + 1));
            if (c < NS + 1) tick();
        end
        tick();
        check_eq("t1_vld", 64'(alrm_vld), 64'd1);
        check_eq("t1_pend", 64'(pend), 64'b0001);
        check_eq("t1_ready", 64'(set_ready), 64'd1);
        cnt = 100;
        push_hit(4'b0001);
        settle(2);
        check_eq("t1_irq", 64'(irq), 64'd1);
        check_eq("t1_pend_clr", 64'(pend), 64'd0);
        settle(6);
        check_eq("t1_idle_vld", 64'(alrm_vld), 64'd0);
        clear_hits(4'b0001);
        check_eq("t1_irq_clr", 64'(irq), 64'd0);

        // Nearest of three, tie on equal times
        cnt = 10;
        push_wr(300);
        do_set(0, 300);
        settle(6);
        push_wr(200);
        do_set(2, 200);
        settle(6);
        push_wr(200);
        do_set(3, 200);
        settle(6);
        check_eq("t2_alrm", 64'(alrm), 64'd200);
        check_eq("t2_pend", 64'(pend), 64'b1101);
        cnt = 200;
        push_hit(4'b1100);
        push_wr(300);
        settle(8);
        check_eq("t2_alrm2", 64'(alrm), 64'd300);
        check_eq("t2_pend2", 64'(pend), 64'b0001);
        cnt = 300;
        push_hit(4'b0001);
        settle(8);
        check_eq("t2_irq", 64'(irq), 64'd1);
        clear_hits(4'b1101);

        // Wrap-around ordering
        cnt = 32'hFFFF_FFF0;
        push_wr(32'h10);
        do_set(1, 32'h10);
        settle(6);
        push_wr(32'hFFFF_FFF8);
        do_set(2, 32'hFFFF_FFF8);
        settle(6);
        check_eq("t3_alrm", 64'(alrm), 64'hFFFF_FFF8);
        cnt = 32'hFFFF_FFF8;
        push_hit(4'b0100);
        push_wr(32'h10);
        settle(8);
        check_eq("t3_alrm2", 64'(alrm), 64'h10);
        cnt = 32'h10;
        push_hit(4'b0010);
        settle(8);
        check_eq("t3_pend", 64'(pend), 64'd0);
        settle(4);
        clear_hits(4'b0110);

        // Cancel the armed slot
        cnt = 50;
        push_wr(100);
        do_set(0, 100);
        settle(6);
        check_eq("t4_vld", 64'(alrm_vld), 64'd1);
        cnt = 60;
        do_cancel(0);
        check_eq("t4_vld_drop", 64'(alrm_vld), 64'd0);
        settle(6);
        check_eq("t4_pend", 64'(pend), 64'd0);
        check_eq("t4_ready", 64'(set_ready), 64'd1);
        cnt = 100;
        settle(6);
        check_eq("t4_irq", 64'(irq), 64'd0);
        check_eq("t4_vld_idle", 64'(alrm_vld), 64'd0);

        // Set beats cancel; set-wins-over-clear on hit status
        cnt = 50;
        push_wr(100);
        do_set(0, 100);
        settle(6);
        push_wr(100);
        set_valid = 1'b1;
        set_id    = 1;
        set_time  = 500;
        cancel    = 1'b1;
        cancel_id = 0;
        tick();
        set_valid = 1'b0;
        cancel    = 1'b0;
        settle(6);
        check_eq("t5_pend", 64'(pend), 64'b0011);
        check_eq("t5_alrm", 64'(alrm), 64'd100);
        cnt = 100;
        push_hit(4'b0001);
        push_wr(500);
        tick();
        hit_clr = 4'b0001;
        tick();
        hit_clr = '0;
        check_eq("t5_irq_set_wins", 64'(irq), 64'd1);
        settle(6);
        check_eq("t5_alrm2", 64'(alrm), 64'd500);
        clear_hits(4'b0001);
        check_eq("t5_irq_clr", 64'(irq), 64'd0);
        do_cancel(1);
        settle(6);
        check_eq("t5_vld", 64'(alrm_vld), 64'd0);

        // Asynchronous reset while armed
        cnt = 50;
        push_wr(100);
        do_set(0, 100);
        settle(6);
        cnt = 100;
        push_hit(4'b0001);
        settle(8);
        push_wr(300);
        do_set(1, 300);
        settle(6);
        check_eq("t6_armed_vld", 64'(alrm_vld), 64'd1);
        check_eq("t6_armed_irq", 64'(irq), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_alrm", 64'(alrm), 64'd0);
        check_eq("t6_rst_vld", 64'(alrm_vld), 64'd0);
        check_eq("t6_rst_pend", 64'(pend), 64'd0);
        check_eq("t6_rst_irq", 64'(irq), 64'd0);
        check_eq("t6_rst_wr", 64'(alrm_wr), 64'd0);
        check_eq("t6_rst_hit", 64'(hit), 64'd0);
        settle(2);
        rst = 1'b0;
        tick();
        check_eq("t6_ready", 64'(set_ready), 64'd1);
        check_eq("t6_pend", 64'(pend), 64'd0);
        settle(4);

        check_eq("sb_drain", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
